// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Three-port single-outstanding memory arbiter. Ports are fetch
//             (0), data (1) and debug (2). Data has fixed priority over the
//             fetch/debug pair, which alternates round-robin. A debug request
//             that loses too many arbitrations in a row wins outright.
//             Each transaction takes three phases: grant (IDLE), memory access
//             (BUSY, bounded by a timeout) and response (RESP).
//  Ports    : clk, reset (async, active-low)
//             req/we[2:0], addrN, wdataN   per-port request side
//             gnt/done[2:0], err, rdata    per-port response side
//             mem_req/we/addr/wdata, mem_rdata, mem_ready   memory side
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 8,
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    req,
  input  logic [2:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] wdata2,
  output logic [2:0]    gnt,
  output logic [2:0]    done,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  localparam int c_SW = $clog2(STARVE_LIM + 1);
  localparam int c_TW = $clog2(TIMEOUT + 1);
  localparam logic [c_SW-1:0] c_SLIM    = c_SW'(STARVE_LIM);
  // The counter holds the number of BUSY cycles already spent without
  // mem_ready, so the last permitted cycle is the one where it reads TIMEOUT-1.
  localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_port;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_rdata;
  logic            r_err;
  logic [c_TW-1:0] r_tcnt;
  logic [c_SW-1:0] r_starve;
  logic            r_rr_dbg;   // 1: debug wins the next fetch/debug contest

  logic [1:0]      w_win;
  logic            w_contest;
  logic            w_arb;
  logic            w_we;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata;

  // Winner selection; only meaningful while some request is pending.
  always_comb begin
    w_win     = 2'd2;
    w_contest = 1'b0;
    if (req[2] && (r_starve == c_SLIM)) begin
      w_win = 2'd2;
    end else if (req[1]) begin
      w_win = 2'd1;
    end else if (req[0] && req[2]) begin
      w_contest = 1'b1;
      w_win     = r_rr_dbg ? 2'd2 : 2'd0;
    end else if (req[0]) begin
      w_win = 2'd0;
    end
  end

  always_comb begin
    w_we    = we[0];
    w_addr  = addr0;
    w_wdata = wdata0;
    case (w_win)
      2'd1: begin
        w_we    = we[1];
        w_addr  = addr1;
        w_wdata = wdata1;
      end
      2'd2: begin
        w_we    = we[2];
        w_addr  = addr2;
        w_wdata = wdata2;
      end
      default: ;
    endcase
  end

  // gnt is combinational from req, so it is gated by reset to stay low
  // while reset is held even though the state register already reads IDLE.
  assign w_arb = reset && (r_state == S_IDLE) && (req != 3'b000);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req != 3'b000) w_next = S_BUSY;
      S_BUSY: if (mem_ready || (r_tcnt == c_TO_LAST)) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_port   <= 2'd0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_tcnt   <= '0;
      r_starve <= '0;
      r_rr_dbg <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (req != 3'b000) begin
            r_port  <= w_win;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_tcnt  <= '0;
            r_err   <= 1'b0;
            // Next contest favours whichever side just lost.
            if (w_contest) r_rr_dbg <= (w_win == 2'd0);
          end
          if (!req[2] || (w_win == 2'd2)) begin
            r_starve <= '0;
          end else if (r_starve != c_SLIM) begin
            r_starve <= r_starve + 1'b1;
          end
        end
        S_BUSY: begin
          // Completion takes precedence over a simultaneous timeout.
          if (mem_ready) begin
            r_err <= 1'b0;
            if (!r_we) r_rdata <= mem_rdata;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
            if (r_tcnt == c_TO_LAST) r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign gnt       = w_arb ? (3'b001 << w_win) : 3'b000;
  assign done      = (r_state == S_RESP) ? (3'b001 << r_port) : 3'b000;
  assign err       = (r_state == S_RESP) && r_err;
  assign rdata     = r_rdata;
  assign mem_req   = (r_state == S_BUSY);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter: directed scenarios plus a
//             randomized run against a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int STARVE_LIM = 4;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    req = '0, we = '0;
  logic [AW-1:0] addr0 = '0, addr1 = '0, addr2 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0, wdata2 = '0;
  logic [2:0]    gnt, done;
  logic          err, mem_req, mem_we;
  logic [DW-1:0] rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(STARVE_LIM), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; we = '0; mem_ready = 1'b0; mem_rdata = '0;
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req = 3'b111; mem_ready = 1'b1;
    #2;
    tests_run++; if (gnt !== 3'b000) begin tests_failed++; $display("FAIL reset_gnt: got %b want 000", gnt); end
    tests_run++; if (done !== 3'b000 || err !== 1'b0) begin tests_failed++; $display("FAIL reset_done_err: got %b/%b want 000/0", done, err); end
    tests_run++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_strobes: got %b/%b want 0/0", mem_req, mem_we); end
    tests_run++; if (mem_addr !== '0 || mem_wdata !== '0 || rdata !== '0) begin tests_failed++; $display("FAIL reset_buses: got %h/%h/%h want 0", mem_addr, mem_wdata, rdata); end
    step();
    tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_held_mem_req: got %b want 0", mem_req); end
  endtask

  task automatic test_single_read();
    do_reset();
    req = 3'b001; addr0 = 16'h0010; we = 3'b000;
    @(negedge clk);
    tests_run++; if (gnt !== 3'b001) begin tests_failed++; $display("FAIL read_gnt: got %b want 001", gnt); end
    step();
    req = 3'b000; mem_ready = 1'b1; mem_rdata = 8'hA5;
    @(negedge clk);
    tests_run++; if (mem_req !== 1'b1 || mem_addr !== 16'h0010 || mem_we !== 1'b0) begin tests_failed++; $display("FAIL read_mem_side: got req=%b addr=%h we=%b want 1/0010/0", mem_req, mem_addr, mem_we); end
    tests_run++; if (done !== 3'b000) begin tests_failed++; $display("FAIL read_early_done: got %b want 000", done); end
    step();
    mem_ready = 1'b0;
    @(negedge clk);
    tests_run++; if (done !== 3'b001 || err !== 1'b0 || rdata !== 8'hA5) begin tests_failed++; $display("FAIL read_done: got done=%b err=%b rdata=%h want 001/0/a5", done, err, rdata); end
    tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL read_resp_mem_req: got %b want 0", mem_req); end
    step();
  endtask

  task automatic test_priority_all();
    logic [2:0] exp_seq [10] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100,
                                 3'b010, 3'b010, 3'b010, 3'b010, 3'b100};
    do_reset();
    req = 3'b111; we = 3'b000; mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests_run++; if (gnt !== exp_seq[i]) begin tests_failed++; $display("FAIL prio_all_gnt[%0d]: got %b want %b", i, gnt, exp_seq[i]); end
      step(); step();
      @(negedge clk);
      tests_run++; if (done !== exp_seq[i]) begin tests_failed++; $display("FAIL prio_all_done[%0d]: got %b want %b", i, done, exp_seq[i]); end
      step();
    end
    req = 3'b000; mem_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    req = 3'b101; we = 3'b000; mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] exp_g;
      exp_g = (i % 2 == 0) ? 3'b001 : 3'b100;
      @(negedge clk);
      tests_run++; if (gnt !== exp_g) begin tests_failed++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt, exp_g); end
      step(); step(); step();
    end
    req = 3'b000; mem_ready = 1'b0;
  endtask

  task automatic test_write_timeout();
    int cnt = 0, bad = 0;
    bit got = 0;
    do_reset();
    req = 3'b010; we = 3'b000; addr1 = 16'h0042; mem_ready = 1'b1; mem_rdata = 8'h77;
    step(); req = 3'b000; step(); mem_ready = 1'b0; step();
    tests_run++; if (rdata !== 8'h77) begin tests_failed++; $display("FAIL wr_prior_read: got %h want 77", rdata); end
    req = 3'b010; we = 3'b010; addr1 = 16'h00FF; wdata1 = 8'h3C; mem_rdata = 8'hEE;
    @(negedge clk);
    tests_run++; if (gnt !== 3'b010) begin tests_failed++; $display("FAIL wr_gnt: got %b want 010", gnt); end
    step();
    req = 3'b000; we = 3'b000;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        cnt++;
        if (mem_addr !== 16'h00FF || mem_wdata !== 8'h3C || mem_we !== 1'b1) bad++;
      end
      if (done !== 3'b000) begin
        got = 1;
        tests_run++; if (done !== 3'b010 || err !== 1'b1 || rdata !== 8'h77) begin tests_failed++; $display("FAIL wr_timeout_done: got done=%b err=%b rdata=%h want 010/1/77", done, err, rdata); end
      end
      step();
    end
    tests_run++; if (!got) begin tests_failed++; $display("FAIL wr_timeout_wait: got no done want done within 40 cycles"); end
    tests_run++; if (cnt != TIMEOUT) begin tests_failed++; $display("FAIL wr_busy_cycles: got %0d want %0d", cnt, TIMEOUT); end
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL wr_mem_stable: got %0d unstable cycles want 0", bad); end
  endtask

  task automatic test_ready_at_limit();
    int cnt = 0;
    do_reset();
    req = 3'b001; we = 3'b000; addr0 = 16'h0AAA;
    step();
    req = 3'b000;
    for (int k = 1; k <= TIMEOUT; k++) begin
      mem_ready = (k == TIMEOUT);
      mem_rdata = (k == TIMEOUT) ? 8'hC3 : 8'h11;
      @(negedge clk);
      if (mem_req === 1'b1) cnt++;
      step();
    end
    mem_ready = 1'b0;
    @(negedge clk);
    tests_run++; if (done !== 3'b001 || err !== 1'b0 || rdata !== 8'hC3) begin tests_failed++; $display("FAIL limit_done: got done=%b err=%b rdata=%h want 001/0/c3", done, err, rdata); end
    tests_run++; if (cnt != TIMEOUT) begin tests_failed++; $display("FAIL limit_busy_cycles: got %0d want %0d", cnt, TIMEOUT); end
    step();
  endtask

  task automatic test_reset_mid_busy();
    int stray = 0;
    do_reset();
    req = 3'b001; we = 3'b000; addr0 = 16'h1234;
    step();
    req = 3'b000;
    step(); step();
    #2;
    reset = 1'b0; req = 3'b010; addr1 = 16'h0BEE;
    #1;
    tests_run++; if (mem_req !== 1'b0 || gnt !== 3'b000) begin tests_failed++; $display("FAIL midbusy_async: got mem_req=%b gnt=%b want 0/000", mem_req, gnt); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done !== 3'b000) stray++;
    end
    tests_run++; if (stray != 0) begin tests_failed++; $display("FAIL midbusy_no_done: got %0d done cycles want 0", stray); end
    reset = 1'b1;
    #1;
    tests_run++; if (gnt !== 3'b010) begin tests_failed++; $display("FAIL midbusy_regnt: got %b want 010", gnt); end
    step();
    tests_run++; if (mem_req !== 1'b1 || mem_addr !== 16'h0BEE) begin tests_failed++; $display("FAIL midbusy_first_edge: got req=%b addr=%h want 1/0bee", mem_req, mem_addr); end
    req = 3'b000; mem_ready = 1'b1;
    step(); step();
    mem_ready = 1'b0;
  endtask

  // Reference model: one outstanding transaction described by its owner,
  // payload and wait count; arbitration fairness tracked as the loser of the
  // previous fetch/debug contest plus a count of consecutive debug losses.
  task automatic test_random(input int ncyc);
    bit busy = 0, resp = 0, eerr = 0, tw = 0;
    int port = 0, waited = 0, starve = 0, last_loser = 0, win, mode = 1;
    logic [AW-1:0] ta = '0;
    logic [DW-1:0] twd = '0, erd = '0;
    logic [2:0] eg, ed;
    int errs_before;
    do_reset();
    errs_before = tests_failed;
    for (int c = 0; c < ncyc; c++) begin
      if (c % 40 == 0) mode = $urandom_range(0, 3);
      req = 3'($urandom); we = 3'($urandom);
      addr0 = 16'($urandom); addr1 = 16'($urandom); addr2 = 16'($urandom);
      wdata0 = 8'($urandom); wdata1 = 8'($urandom); wdata2 = 8'($urandom);
      mem_rdata = 8'($urandom);
      mem_ready = (mode == 0) ? 1'b0 : ($urandom_range(0, 2) == 0);
      @(negedge clk);
      eg = 3'b000; ed = 3'b000; win = -1;
      if (!busy && !resp && req != 3'b000) begin
        if (req[2] && starve == STARVE_LIM) win = 2;
        else if (req[1]) win = 1;
        else if (req[0] && req[2]) begin
          win = last_loser;
          last_loser = (win == 0) ? 2 : 0;
        end
        else if (req[0]) win = 0;
        else win = 2;
        eg = 3'b001 << win;
      end
      if (resp) ed = 3'b001 << port;
      tests_run++; if (gnt !== eg) begin tests_failed++; $display("FAIL rnd_gnt@%0d: got %b want %b", c, gnt, eg); end
      tests_run++; if (done !== ed || err !== (resp && eerr)) begin tests_failed++; $display("FAIL rnd_done@%0d: got %b/%b want %b/%b", c, done, err, ed, resp && eerr); end
      tests_run++; if (mem_req !== busy || rdata !== erd) begin tests_failed++; $display("FAIL rnd_memreq_rdata@%0d: got %b/%h want %b/%h", c, mem_req, rdata, busy, erd); end
      if (busy) begin
        tests_run++; if (mem_addr !== ta || mem_we !== tw || mem_wdata !== twd) begin tests_failed++; $display("FAIL rnd_mem_bus@%0d: got %h/%b/%h want %h/%b/%h", c, mem_addr, mem_we, mem_wdata, ta, tw, twd); end
      end
      // advance the model across the coming clock edge
      if (resp) begin
        resp = 0;
      end else if (busy) begin
        if (mem_ready) begin
          if (!tw) erd = mem_rdata;
          eerr = 0; busy = 0; resp = 1;
        end else begin
          waited++;
          if (waited == TIMEOUT) begin eerr = 1; busy = 0; resp = 1; end
        end
      end else begin
        if (win >= 0) begin
          port = win; tw = we[win]; busy = 1; waited = 0;
          ta  = (win == 0) ? addr0 : (win == 1) ? addr1 : addr2;
          twd = (win == 0) ? wdata0 : (win == 1) ? wdata1 : wdata2;
        end
        if (!req[2] || win == 2) starve = 0;
        else if (starve < STARVE_LIM) starve++;
      end
      step();
      if (tests_failed - errs_before > 20) break;
    end
    req = 3'b000; mem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_priority_all();
    test_round_robin();
    test_write_timeout();
    test_ready_at_limit();
    test_reset_mid_busy();
    test_random(600);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 16, memory address width.
REQ-002 Parameter DW, default 8, memory data width.
REQ-003 Parameter STARVE_LIM, default 4, consecutive lost arbitrations after which the debug port wins unconditionally.
REQ-004 Parameter TIMEOUT, default 15, maximum BUSY cycles waiting for mem_ready.
REQ-005 clk  in  1  single clock; all state is updated on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset; 0 = reset.
REQ-007 req[2:0]  in  3  per-port request: 0 = fetch, 1 = data (load/pop/push), 2 = debug.
REQ-008 we[2:0]  in  3  per-port write enable.
REQ-009 addr0/addr1/addr2  in  AW each  per-port address.
REQ-010 wdata0/wdata1/wdata2  in  DW each  per-port write data.
REQ-011 gnt[2:0]  out  3  one-cycle pulse when the port's request is accepted.
REQ-012 done[2:0]  out  3  one-cycle pulse when the port's transaction completes.
REQ-013 err  out  1  valid with done: 1 = the transaction timed out.
REQ-014 rdata  out  DW  read data; valid in the done cycle and held until the next done.
REQ-015 mem_req, mem_we  out  1 each  memory strobe and write enable.
REQ-016 mem_addr, mem_wdata  out  AW, DW  memory address and write data.
REQ-017 mem_rdata  in  DW  memory read data, sampled when mem_ready = 1.
REQ-018 mem_ready  in  1  memory completion.

Function
REQ-019 FSM states: IDLE, BUSY, RESP.
- IDLE -> BUSY when any req bit = 1.
- BUSY -> RESP on mem_ready = 1 or on timeout.
- RESP -> IDLE unconditionally.
REQ-020 Arbitration happens only in IDLE; exactly one gnt bit pulses in the IDLE cycle that leads to BUSY.
REQ-021 Priority, evaluated in order:
- (a) debug, if its starvation count = STARVE_LIM and req[2] = 1;
- (b) data;
- (c) fetch vs. debug, round-robin: the loser of the last fetch/debug contest wins. The round-robin bit resets to favour fetch.
REQ-022 The debug starvation count increments (saturating at STARVE_LIM) each arbitration in which req[2] = 1 and debug is not granted. It clears when debug is granted or when req[2] = 0 in IDLE.
REQ-023 On grant, the winner's we/addr/wdata and port index are registered. mem_req, mem_we, mem_addr and mem_wdata are driven from these registers for every BUSY cycle and are stable throughout BUSY.
REQ-024 mem_req = 1 only in BUSY; mem_req = 0 in IDLE and RESP.
REQ-025 Dropping req after gnt has no effect; the transaction always completes.
REQ-026 A timeout counter clears on entry to BUSY and increments each BUSY cycle with mem_ready = 0. When the counter reaches TIMEOUT, the next state is RESP with err = 1.
REQ-027 rdata captures mem_rdata on the BUSY cycle where mem_ready = 1 and we = 0. On a write or a timeout, rdata is unchanged.
REQ-028 In RESP, done[granted port] = 1 for one cycle and err is driven. Minimum transaction latency is gnt cycle + 1 BUSY cycle + RESP = 3 cycles.
REQ-029 A port's req held high continuously is re-arbitrated on the IDLE cycle after RESP; back-to-back throughput is one transaction per 3 cycles.
REQ-030 mem_ready = 1 and counter = TIMEOUT in the same cycle: the completion wins and err = 0.
REQ-031 mem_ready while in IDLE or RESP is ignored.

Reset
REQ-032 While reset = 0: state = IDLE; gnt = 0, done = 0, err = 0, mem_req = 0, mem_we = 0; mem_addr, mem_wdata and rdata = 0; all counters = 0; round-robin favours fetch. This takes effect immediately, not at the next clock edge.
REQ-033 Reset asserted during BUSY aborts the transaction: no done is issued, and mem_req drops asynchronously.
REQ-034 After reset deasserts, the first arbitration may occur on the first rising edge.

Verification
REQ-035 Single fetch read: req = 001, addr0 = 0x0010, mem_ready one cycle after mem_req with mem_rdata = 0xA5. Expect:
- gnt = 001;
- mem_addr = 0x0010, mem_we = 0;
- done = 001 two cycles after gnt, rdata = 0xA5, err = 0.
REQ-036 All ports requesting (req = 111) continuously, mem_ready always 1, STARVE_LIM = 4. Expect grant sequence data, data, data, data, debug, data, ...
REQ-037 req = 101 continuously with mem_ready = 1. Expect grants to alternate fetch, debug, fetch, debug, starting with fetch.
REQ-038 Data write: we1 = 1, addr1 = 0x00FF, wdata1 = 0x3C, mem_ready held 0. Expect:
- mem_req held for 15 cycles;
- then done = 010, err = 1;
- rdata unchanged.
REQ-039 mem_ready rises on exactly the 15th BUSY cycle. Expect done with err = 0 and rdata = mem_rdata.
REQ-040 reset = 0 pulse mid-BUSY. Expect mem_req = 0 immediately and no done pulse. After release, a pending req = 010 is granted on the first edge.
